// File: rtl/block_match_cost_pkg.sv
// Shared types and width helpers for the block-matcher cost stage.
package block_match_cost_pkg;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
    } coord_t;

    // Candidate beats and the sweep-end marker travel the same number of stages.
    localparam int PIPE_LAT = 4;

    function automatic int cost_width(input int bw, input int bh);
        return $clog2(bw * bh + 1);
    endfunction

    function automatic int row_count_width(input int bw);
        return $clog2(bw + 1);
    endfunction

endpackage

// File: rtl/block_match_cost_if.sv
// Candidate stream in, single best-match result out (valid/ready).
interface block_match_cost_if
    import block_match_cost_pkg::*;
#(
    parameter int BW     = 16,
    parameter int BH     = 16,
    parameter int COST_W = cost_width(BW, BH)
) ();

    logic [BW*BH-1:0]  blk_block;
    logic [BW*BH-1:0]  srch_block;
    coord_t            coords_in;
    logic [15:0]       blk_index_in;
    logic              blks_valid;
    logic              match_done;

    logic              res_valid;
    logic              res_ready;
    coord_t            res_coords;
    logic [COST_W-1:0] res_cost;
    logic [15:0]       res_index;
    logic              overflow;

    modport slave (
        input  blk_block, srch_block, coords_in, blk_index_in, blks_valid, match_done,
        input  res_ready,
        output res_valid, res_coords, res_cost, res_index, overflow
    );

    modport master (
        output blk_block, srch_block, coords_in, blk_index_in, blks_valid, match_done,
        output res_ready,
        input  res_valid, res_coords, res_cost, res_index, overflow
    );

endinterface

// File: rtl/block_match_cost_row_popcount.sv
// Combinational population count of one block row.
module block_match_cost_row_popcount
    import block_match_cost_pkg::*;
#(
    parameter int BW   = 16,
    localparam int CW  = row_count_width(BW)
) (
    input  logic [BW-1:0] row_i,
    output logic [CW-1:0] count_o
);

    // Count the set bits of the row.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < BW; i++) begin
            count_o = count_o + CW'(row_i[i]);
        end
    end

endmodule

// File: rtl/block_match_cost.sv
// Hamming-cost pipeline with per-sweep minimum tracking and a one-entry result buffer.
module block_match_cost
    import block_match_cost_pkg::*;
#(
    parameter int BLOCK_WIDTH  = 16,
    parameter int BLOCK_HEIGHT = 16,
    localparam int COST_W      = cost_width(BLOCK_WIDTH, BLOCK_HEIGHT),
    localparam int RC_W        = row_count_width(BLOCK_WIDTH),
    localparam int NPIX        = BLOCK_WIDTH * BLOCK_HEIGHT
) (
    input  logic                clk,
    input  logic                reset,
    block_match_cost_if.slave   bus
);

    // Stage registers
    logic [NPIX-1:0]   xor_q;
    logic              s1_valid_q, s2_valid_q, s3_valid_q;
    coord_t            s1_coords_q, s2_coords_q, s3_coords_q;
    logic [15:0]       s1_index_q, s2_index_q, s3_index_q;
    logic [RC_W-1:0]   rowcnt_d [BLOCK_HEIGHT];
    logic [RC_W-1:0]   rowcnt_q [BLOCK_HEIGHT];
    logic [COST_W-1:0] cost_d, cost_q;

    // Sweep-end marker: edge detect plus delay line aligned with the S4 compare.
    logic                done_prev_q;
    logic                done_edge_s;
    logic [PIPE_LAT-2:0] fin_q;
    logic                finalize_s;

    // Minimum tracker and result buffer
    logic              sweep_active_q;
    logic [COST_W-1:0] best_cost_q;
    coord_t            best_coords_q;
    logic [15:0]       sweep_idx_q;
    logic              res_valid_q;
    coord_t            res_coords_q;
    logic [COST_W-1:0] res_cost_q;
    logic [15:0]       res_index_q;
    logic              overflow_q;

    logic              take_d;
    logic [COST_W-1:0] best_cost_d;
    coord_t            best_coords_d;
    logic [15:0]       sweep_idx_d;
    logic              sweep_active_d;
    logic              accept_s;

    assign done_edge_s = bus.match_done & ~done_prev_q;
    assign finalize_s  = fin_q[PIPE_LAT-2];
    assign accept_s    = res_valid_q & bus.res_ready;

    for (genvar r = 0; r < BLOCK_HEIGHT; r++) begin : g_row
        block_match_cost_row_popcount #(.BW(BLOCK_WIDTH)) u_popcount (
            .row_i   (xor_q[r*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .count_o (rowcnt_d[r])
        );
    end

    // Sum of row counts; the full-block count always fits COST_W.
    always_comb begin
        cost_d = '0;
        for (int r = 0; r < BLOCK_HEIGHT; r++) begin
            cost_d = cost_d + COST_W'(rowcnt_q[r]);
        end
    end

    // Stages S1..S3 and the sweep-end delay line; the pipe never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            xor_q       <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            s1_coords_q <= '0;
            s2_coords_q <= '0;
            s3_coords_q <= '0;
            s1_index_q  <= 16'h0000;
            s2_index_q  <= 16'h0000;
            s3_index_q  <= 16'h0000;
            cost_q      <= '0;
            done_prev_q <= 1'b0;
            fin_q       <= '0;
            for (int r = 0; r < BLOCK_HEIGHT; r++) begin
                rowcnt_q[r] <= '0;
            end
        end else begin
            xor_q       <= bus.blk_block ^ bus.srch_block;
            s1_valid_q  <= bus.blks_valid;
            s1_coords_q <= bus.coords_in;
            s1_index_q  <= bus.blk_index_in;
            for (int r = 0; r < BLOCK_HEIGHT; r++) begin
                rowcnt_q[r] <= rowcnt_d[r];
            end
            s2_valid_q  <= s1_valid_q;
            s2_coords_q <= s1_coords_q;
            s2_index_q  <= s1_index_q;
            cost_q      <= cost_d;
            s3_valid_q  <= s2_valid_q;
            s3_coords_q <= s2_coords_q;
            s3_index_q  <= s2_index_q;
            done_prev_q <= bus.match_done;
            fin_q       <= {fin_q[PIPE_LAT-3:0], done_edge_s};
        end
    end

    // S4 merge: the beat in S3 folds into the running best before any finalize uses it.
    always_comb begin
        if (s3_valid_q && (!sweep_active_q || (cost_q < best_cost_q))) begin
            take_d = 1'b1;
        end else begin
            take_d = 1'b0;
        end
        if (take_d) begin
            best_cost_d   = cost_q;
            best_coords_d = s3_coords_q;
        end else begin
            best_cost_d   = best_cost_q;
            best_coords_d = best_coords_q;
        end
        if (s3_valid_q && !sweep_active_q) begin
            sweep_idx_d = s3_index_q;
        end else begin
            sweep_idx_d = sweep_idx_q;
        end
        sweep_active_d = sweep_active_q | s3_valid_q;
    end

    // Minimum tracking, finalize and result buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_active_q <= 1'b0;
            best_cost_q    <= '1;
            best_coords_q  <= '0;
            sweep_idx_q    <= 16'h0000;
            res_valid_q    <= 1'b0;
            res_coords_q   <= '0;
            res_cost_q     <= '0;
            res_index_q    <= 16'h0000;
            overflow_q     <= 1'b0;
        end else if (finalize_s) begin
            sweep_active_q <= 1'b0;
            best_cost_q    <= '1;
            best_coords_q  <= best_coords_d;
            sweep_idx_q    <= sweep_idx_d;
            if (sweep_active_d && (!res_valid_q || bus.res_ready)) begin
                res_valid_q  <= 1'b1;
                res_coords_q <= best_coords_d;
                res_cost_q   <= best_cost_d;
                res_index_q  <= sweep_idx_d;
            end else if (sweep_active_d) begin
                overflow_q   <= 1'b1;
            end else if (accept_s) begin
                res_valid_q  <= 1'b0;
            end else begin
                res_valid_q  <= res_valid_q;
            end
        end else begin
            sweep_active_q <= sweep_active_d;
            best_cost_q    <= best_cost_d;
            best_coords_q  <= best_coords_d;
            sweep_idx_q    <= sweep_idx_d;
            if (accept_s) begin
                res_valid_q <= 1'b0;
            end else begin
                res_valid_q <= res_valid_q;
            end
        end
    end

    assign bus.res_valid  = res_valid_q;
    assign bus.res_coords = res_coords_q;
    assign bus.res_cost   = res_cost_q;
    assign bus.res_index  = res_index_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_block_match_cost.sv
// Directed bench for block_match_cost: vector table of single-beat sweeps plus corner sequences.
module tb_block_match_cost;

    localparam int BW = 16;
    localparam int BH = 16;
    localparam int N  = BW * BH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    block_match_cost_if #(.BW(BW), .BH(BH)) bus ();

    block_match_cost #(.BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] p;
        logic [15:0] q;
        logic [15:0] coords;
        logic [15:0] idx;
        int          cost;
    } vec_t;

    vec_t vecs [7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] rows_of(input logic [15:0] p);
        logic [N-1:0] b;
        for (int r = 0; r < BH; r++) b[r*BW +: BW] = p;
        return b;
    endfunction

    function automatic logic [N-1:0] ones_block(input int n);
        logic [N-1:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [N-1:0] random_block();
        logic [N-1:0] b;
        for (int w = 0; w < N / 32; w++) b[w*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic send_beat(input logic [N-1:0] b, input logic [N-1:0] s,
                             input logic [15:0] c, input logic [15:0] idx);
        bus.blk_block    = b;
        bus.srch_block   = s;
        bus.coords_in    = c;
        bus.blk_index_in = idx;
        bus.blks_valid   = 1'b1;
        tick();
        bus.blks_valid   = 1'b0;
    endtask

    task automatic done_pulse();
        bus.match_done = 1'b1;
        tick();
        bus.match_done = 1'b0;
    endtask

    task automatic wait_res(input string name);
        int k;
        k = 0;
        while (!bus.res_valid && k < 20) begin
            tick();
            k++;
        end
        check({name, "_timeout"}, 32'(bus.res_valid), 1);
    endtask

    task automatic accept(input string name);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({name, "_drop"}, 32'(bus.res_valid), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0000, 16'h1000, 16'h0020, 256};
        vecs[1] = '{16'hAAAA, 16'h5555, 16'h1001, 16'h0021, 256};
        vecs[2] = '{16'hAAAA, 16'hAAAA, 16'h1002, 16'h0022, 0};
        vecs[3] = '{16'h00FF, 16'h0000, 16'h1003, 16'h0023, 128};
        vecs[4] = '{16'h0001, 16'h0000, 16'h1004, 16'h0024, 16};
        vecs[5] = '{16'h8421, 16'h0000, 16'h1005, 16'h0025, 64};
        vecs[6] = '{16'hF000, 16'h0F00, 16'h1006, 16'h0026, 128};

        bus.blk_block    = '0;
        bus.srch_block   = '0;
        bus.coords_in    = '0;
        bus.blk_index_in = 16'h0000;
        bus.blks_valid   = 1'b0;
        bus.match_done   = 1'b0;
        bus.res_ready    = 1'b0;
        do_reset();

        check("rst_valid",    32'(bus.res_valid), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_cost",     32'(bus.res_cost), 0);
        check("rst_coords",   32'(bus.res_coords), 0);
        check("rst_index",    32'(bus.res_index), 0);

        // Table: one beat per sweep.
        for (int i = 0; i < 7; i++) begin
            send_beat(rows_of(vecs[i].p), rows_of(vecs[i].q), vecs[i].coords, vecs[i].idx);
            done_pulse();
            wait_res($sformatf("vec%0d", i));
            check($sformatf("vec%0d_cost", i),   32'(bus.res_cost),   vecs[i].cost);
            check($sformatf("vec%0d_coords", i), 32'(bus.res_coords), 32'(vecs[i].coords));
            check($sformatf("vec%0d_index", i),  32'(bus.res_index),  32'(vecs[i].idx));
            accept($sformatf("vec%0d", i));
        end

        // Latency: result appears exactly 4 cycles after the done edge.
        send_beat(ones_block(N), '0, 16'h0102, 16'h0009);
        bus.match_done = 1'b1;
        tick();
        bus.match_done = 1'b0;
        tick();
        tick();
        check("lat_early", 32'(bus.res_valid), 0);
        tick();
        check("lat_valid", 32'(bus.res_valid), 1);
        check("lat_cost",  32'(bus.res_cost), 256);
        accept("lat");

        // Exact match hidden among random nonzero-cost beats, with a gap.
        for (int i = 0; i < 6; i++) begin
            logic [N-1:0] b;
            b = random_block();
            if (i == 3) send_beat(b, b, 16'h0203, 16'h0030);
            else        send_beat(b, b ^ ones_block(1 + i * 7), 16'h0100 + 16'(i), 16'h0030);
            if (i == 2) tick();
        end
        done_pulse();
        wait_res("exact");
        check("exact_cost",   32'(bus.res_cost), 0);
        check("exact_coords", 32'(bus.res_coords), 32'h0203);
        check("exact_index",  32'(bus.res_index), 32'h0030);
        accept("exact");

        // Ties: 50,20,20,90 -> first 20 wins.
        send_beat('0, ones_block(50), 16'h0500, 16'h0040);
        send_beat('0, ones_block(20), 16'h0501, 16'h0040);
        tick();
        send_beat('0, ones_block(20), 16'h0502, 16'h0040);
        send_beat('0, ones_block(90), 16'h0503, 16'h0040);
        done_pulse();
        wait_res("tie");
        check("tie_cost",   32'(bus.res_cost), 20);
        check("tie_coords", 32'(bus.res_coords), 32'h0501);
        accept("tie");

        // Done edge in the same cycle as the only beat: beat still counts.
        bus.blk_block    = ones_block(10);
        bus.srch_block   = '0;
        bus.coords_in    = 16'h0607;
        bus.blk_index_in = 16'h0050;
        bus.blks_valid   = 1'b1;
        bus.match_done   = 1'b1;
        tick();
        bus.blks_valid   = 1'b0;
        bus.match_done   = 1'b0;
        wait_res("merge");
        check("merge_cost",   32'(bus.res_cost), 10);
        check("merge_coords", 32'(bus.res_coords), 32'h0607);
        accept("merge");

        // Done edge with no beats: nothing produced.
        done_pulse();
        repeat (8) tick();
        check("empty_valid",    32'(bus.res_valid), 0);
        check("empty_overflow", 32'(bus.overflow), 0);

        // Overflow: second result dropped while first is held.
        send_beat(ones_block(5), '0, 16'h0A0B, 16'h0001);
        done_pulse();
        repeat (6) tick();
        send_beat(ones_block(3), '0, 16'h0C0D, 16'h0002);
        done_pulse();
        repeat (6) tick();
        check("ovf_valid",  32'(bus.res_valid), 1);
        check("ovf_flag",   32'(bus.overflow), 1);
        check("ovf_index",  32'(bus.res_index), 1);
        check("ovf_cost",   32'(bus.res_cost), 5);
        check("ovf_coords", 32'(bus.res_coords), 32'h0A0B);
        accept("ovf");
        check("ovf_sticky", 32'(bus.overflow), 1);
        do_reset();
        check("ovf_cleared", 32'(bus.overflow), 0);

        // Reset mid-sweep: the abandoned sweep leaves no trace.
        send_beat(ones_block(1), '0, 16'h0303, 16'h0003);
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 32'(bus.res_valid), 0);
        send_beat(ones_block(100), '0, 16'h0707, 16'h0007);
        done_pulse();
        wait_res("mid_rst");
        check("mid_rst_index",  32'(bus.res_index), 7);
        check("mid_rst_cost",   32'(bus.res_cost), 100);
        check("mid_rst_coords", 32'(bus.res_coords), 32'h0707);
        accept("mid_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
